// File: rtl/wb_queue_pkg.sv
// rtl/wb_queue_pkg.sv - shared widths, zero-register index and queue entry type
package wb_queue_pkg;

    localparam int WB_DATA_W = 64;
    localparam int WB_ADDR_W = 5;
    localparam int WB_ZR_IDX = 31;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - in-order write-back FIFO with dual push, single pop and age-ordered view
module wb_fifo
    import wb_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push0,
    input  wb_entry_t        entry0,
    input  logic             push1,
    input  wb_entry_t        entry1,
    input  logic             pop,
    output wb_entry_t        head_entry,
    output wb_entry_t        view [DEPTH],
    output logic [CNT_W-1:0] count
);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             pop_en;

    assign pop_en = pop && (count != '0);

    // push0 is always the older entry when both arrive together
    always_ff @(posedge clk) begin
        if (push0 && push1) begin
            mem[tail]              <= entry0;
            mem[tail + PTR_W'(1)]  <= entry1;
        end else if (push0) begin
            mem[tail] <= entry0;
        end else if (push1) begin
            mem[tail] <= entry1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            tail  <= tail + PTR_W'(push0) + PTR_W'(push1);
            if (pop_en) begin
                head <= head + PTR_W'(1);
            end
            count <= count + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop_en);
        end
    end

    assign head_entry = mem[head];

    // view[0] is the oldest entry; only the first count slots are meaningful
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            view[i] = mem[head + PTR_W'(i)];
        end
    end

endmodule

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - write-back queue: enqueue filter, stall, retire register and bypass lookups
module wb_queue
    import wb_queue_pkg::*;
#(
    parameter  int DEPTH  = 4,
    parameter  int DATA_W = WB_DATA_W,
    parameter  int ADDR_W = WB_ADDR_W,
    parameter  int ZR_IDX = WB_ZR_IDX,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              MemWrValid,
    input  logic [ADDR_W-1:0] MemRd,
    input  logic [DATA_W-1:0] MemData,
    input  logic              AluWrValid,
    input  logic [ADDR_W-1:0] AluRd,
    input  logic [DATA_W-1:0] AluData,
    output logic              Stall,
    output logic              RegWr,
    output logic [ADDR_W-1:0] RW,
    output logic [DATA_W-1:0] BusW,
    input  logic [ADDR_W-1:0] LookA,
    input  logic [ADDR_W-1:0] LookB,
    output logic              HitA,
    output logic              HitB,
    output logic [DATA_W-1:0] HitDataA,
    output logic [DATA_W-1:0] HitDataB,
    output logic [CNT_W-1:0]  Count
);

    wb_entry_t mem_entry;
    wb_entry_t alu_entry;
    wb_entry_t head_entry;
    wb_entry_t view [DEPTH];
    logic      mem_push;
    logic      alu_push;
    logic      pop;

    // two free slots whenever Stall is low, so a dual push can never overflow
    assign Stall    = (Count >= CNT_W'(DEPTH - 1));
    assign mem_push = MemWrValid && !Stall && (MemRd != ADDR_W'(ZR_IDX));
    assign alu_push = AluWrValid && !Stall && (AluRd != ADDR_W'(ZR_IDX));
    assign mem_entry = '{rd: MemRd, data: MemData};
    assign alu_entry = '{rd: AluRd, data: AluData};
    assign pop       = (Count != '0);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .push0      (mem_push),
        .entry0     (mem_entry),
        .push1      (alu_push),
        .entry1     (alu_entry),
        .pop        (pop),
        .head_entry (head_entry),
        .view       (view),
        .count      (Count)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            RegWr <= 1'b0;
            RW    <= ADDR_W'(ZR_IDX);
            BusW  <= '0;
        end else begin
            RegWr <= pop;
            if (pop) begin
                RW   <= head_entry.rd;
                BusW <= head_entry.data;
            end
        end
    end

    // later matches overwrite earlier ones, so the youngest pending write wins
    function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] addr);
        logic              hit;
        logic [DATA_W-1:0] data;
        hit  = 1'b0;
        data = '0;
        if (addr != ADDR_W'(ZR_IDX)) begin
            if (RegWr && (RW == addr)) begin
                hit  = 1'b1;
                data = BusW;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if ((i < int'(Count)) && (view[i].rd == addr)) begin
                    hit  = 1'b1;
                    data = view[i].data;
                end
            end
        end
        return {hit, data};
    endfunction

    always_comb begin
        {HitA, HitDataA} = lookup(LookA);
        {HitB, HitDataB} = lookup(LookB);
    end

endmodule

// File: tb/tb_wb_queue.sv
// tb/tb_wb_queue.sv - directed self-checking bench for wb_queue
module tb_wb_queue;

    localparam int DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        MemWrValid;
    logic [4:0]  MemRd;
    logic [63:0] MemData;
    logic        AluWrValid;
    logic [4:0]  AluRd;
    logic [63:0] AluData;
    logic        Stall;
    logic        RegWr;
    logic [4:0]  RW;
    logic [63:0] BusW;
    logic [4:0]  LookA;
    logic [4:0]  LookB;
    logic        HitA;
    logic        HitB;
    logic [63:0] HitDataA;
    logic [63:0] HitDataB;
    logic [2:0]  Count;

    int checks = 0;
    int errors = 0;

    logic [68:0] retired [$];
    logic [68:0] expq [$];

    wb_queue #(.DEPTH(DEPTH)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .MemWrValid (MemWrValid),
        .MemRd      (MemRd),
        .MemData    (MemData),
        .AluWrValid (AluWrValid),
        .AluRd      (AluRd),
        .AluData    (AluData),
        .Stall      (Stall),
        .RegWr      (RegWr),
        .RW         (RW),
        .BusW       (BusW),
        .LookA      (LookA),
        .LookB      (LookB),
        .HitA       (HitA),
        .HitB       (HitB),
        .HitDataA   (HitDataA),
        .HitDataB   (HitDataB),
        .Count      (Count)
    );

    always #5 Clk = ~Clk;

    // RegWr is high for a whole cycle, so each retire is seen at exactly one negedge
    always @(negedge Clk) begin
        if (Reset_n && RegWr) begin
            retired.push_back({RW, BusW});
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic mv, input logic [4:0] mrd, input logic [63:0] md,
                         input logic av, input logic [4:0] ard, input logic [63:0] ad);
        MemWrValid = mv;
        MemRd      = mrd;
        MemData    = md;
        AluWrValid = av;
        AluRd      = ard;
        AluData    = ad;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    endtask

    task automatic check_retired(input string tag);
        check({tag, "_len"}, 64'(retired.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size() && i < retired.size(); i++) begin
            check({tag, "_rd"}, 64'(retired[i][68:64]), 64'(expq[i][68:64]));
            check({tag, "_data"}, retired[i][63:0], expq[i][63:0]);
        end
    endtask

    initial begin
        Reset_n = 1'b0;
        LookA   = 5'd0;
        LookB   = 5'd0;
        idle();
        tick();
        tick();
        check("rst_regwr", 64'(RegWr), 64'd0);
        check("rst_rw", 64'(RW), 64'd31);
        check("rst_busw", BusW, 64'd0);
        check("rst_stall", 64'(Stall), 64'd0);
        check("rst_count", 64'(Count), 64'd0);
        check("rst_hita", 64'(HitA), 64'd0);
        check("rst_hitb", 64'(HitB), 64'd0);
        Reset_n = 1'b1;
        tick();

        // single ALU write
        retired.delete();
        expq.delete();
        LookA = 5'd5;
        drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 64'h1234);
        tick();
        idle();
        check("single_count1", 64'(Count), 64'd1);
        check("single_regwr0", 64'(RegWr), 64'd0);
        check("single_hit_q", 64'(HitA), 64'd1);
        check("single_hitdata_q", HitDataA, 64'h1234);
        tick();
        check("single_regwr1", 64'(RegWr), 64'd1);
        check("single_rw", 64'(RW), 64'd5);
        check("single_busw", BusW, 64'h1234);
        check("single_count0", 64'(Count), 64'd0);
        check("single_hit_out", 64'(HitA), 64'd1);
        tick();
        check("single_regwr_off", 64'(RegWr), 64'd0);
        check("single_rw_hold", 64'(RW), 64'd5);
        check("single_hit_gone", 64'(HitA), 64'd0);
        expq.push_back({5'd5, 64'h1234});
        check_retired("single_ret");

        // same-register Mem and ALU in one cycle
        retired.delete();
        expq.delete();
        LookA = 5'd3;
        LookB = 5'd4;
        drive(1'b1, 5'd3, 64'hAA, 1'b1, 5'd3, 64'hBB);
        tick();
        idle();
        check("dual_count2", 64'(Count), 64'd2);
        check("dual_stall", 64'(Stall), 64'd0);
        check("dual_hita", 64'(HitA), 64'd1);
        check("dual_hitdata_both", HitDataA, 64'hBB);
        check("dual_hitb", 64'(HitB), 64'd0);
        check("dual_hitdatab", HitDataB, 64'd0);
        tick();
        check("dual_first_busw", BusW, 64'hAA);
        check("dual_hitdata_mid", HitDataA, 64'hBB);
        tick();
        check("dual_second_busw", BusW, 64'hBB);
        check("dual_hitdata_out", HitDataA, 64'hBB);
        tick();
        expq.push_back({5'd3, 64'hAA});
        expq.push_back({5'd3, 64'hBB});
        check_retired("dual_ret");

        // fill to Stall; requests presented during Stall must be dropped
        retired.delete();
        expq.delete();
        drive(1'b1, 5'd1, 64'h101, 1'b1, 5'd2, 64'h102);
        tick();
        check("fill_count2", 64'(Count), 64'd2);
        check("fill_stall_c2", 64'(Stall), 64'd0);
        drive(1'b1, 5'd4, 64'h104, 1'b1, 5'd6, 64'h106);
        tick();
        check("fill_count3", 64'(Count), 64'd3);
        check("fill_stall_c3", 64'(Stall), 64'd1);
        drive(1'b1, 5'd7, 64'hBAD0, 1'b1, 5'd8, 64'hBAD1);
        tick();
        check("fill_drop_count", 64'(Count), 64'd2);
        check("fill_stall_c2b", 64'(Stall), 64'd0);
        drive(1'b1, 5'd9, 64'h109, 1'b1, 5'd10, 64'h10A);
        tick();
        check("fill_count3b", 64'(Count), 64'd3);
        idle();
        for (int i = 0; i < 6; i++) tick();
        check("fill_drained", 64'(Count), 64'd0);
        expq.push_back({5'd1, 64'h101});
        expq.push_back({5'd2, 64'h102});
        expq.push_back({5'd4, 64'h104});
        expq.push_back({5'd6, 64'h106});
        expq.push_back({5'd9, 64'h109});
        expq.push_back({5'd10, 64'h10A});
        check_retired("fill_ret");

        // writes to the zero register
        retired.delete();
        expq.delete();
        LookA = 5'd31;
        drive(1'b1, 5'd31, 64'hFFFF, 1'b1, 5'd31, 64'hFFFF);
        tick();
        idle();
        check("zr_count", 64'(Count), 64'd0);
        check("zr_hita", 64'(HitA), 64'd0);
        tick();
        check("zr_regwr", 64'(RegWr), 64'd0);
        check("zr_hita_after", 64'(HitA), 64'd0);
        check_retired("zr_ret");

        // 20-write stream, wraps the pointers several times
        retired.delete();
        expq.delete();
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 5'd0, 64'd0, 1'b1, 5'(i), 64'h1000 + 64'(i));
            expq.push_back({5'(i), 64'h1000 + 64'(i)});
            tick();
            check("stream_count_le1", 64'(Count <= 3'd1), 64'd1);
        end
        idle();
        for (int i = 0; i < 3; i++) tick();
        check_retired("stream_ret");

        // asynchronous reset with three entries queued
        retired.delete();
        expq.delete();
        drive(1'b1, 5'd1, 64'h201, 1'b1, 5'd2, 64'h202);
        tick();
        drive(1'b1, 5'd3, 64'h203, 1'b1, 5'd4, 64'h204);
        tick();
        idle();
        check("mid_count3", 64'(Count), 64'd3);
        check("mid_regwr_before", 64'(RegWr), 64'd1);
        #1;
        Reset_n = 1'b0;
        #1;
        check("mid_regwr_async", 64'(RegWr), 64'd0);
        check("mid_count_async", 64'(Count), 64'd0);
        tick();
        tick();
        Reset_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("mid_count_after", 64'(Count), 64'd0);
        check_retired("mid_ret");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_queue.md
Name: wb_queue

Overview:
- Write-back side of the 64-bit, 32-entry register file interface; the block drives that file's write port.
- Accepts result writes from the ALU path and the data-memory load path.
- Buffers pending writes in a small in-order FIFO and retires one write per cycle onto RegWr/RW/BusW.
- Provides youngest-match bypass lookups on two read addresses so the datapath can see pending values before they reach the file.

Parameters:
- DEPTH, 4, FIFO entries (power of two, at least 2).
- DATA_W, 64, write data width.
- ADDR_W, 5, register address width.
- ZR_IDX, 31, index of the hardwired zero register XZR.

Ports:
- Clk  in  1  system clock; all state updates on posedge.
- Reset_n  in  1  asynchronous, active-low reset.
- MemWrValid  in  1  load result write request.
- MemRd  in  ADDR_W  load destination register.
- MemData  in  DATA_W  load data.
- AluWrValid  in  1  ALU result write request.
- AluRd  in  ADDR_W  ALU destination register.
- AluData  in  DATA_W  ALU result.
- Stall  out  1  producers must hold requests; the block ignores inputs while high.
- RegWr  out  1  register file write enable.
- RW  out  ADDR_W  register file write address.
- BusW  out  DATA_W  register file write data.
- LookA, LookB  in  ADDR_W  bypass lookup addresses.
- HitA, HitB  out  1  a pending write to LookA/LookB exists.
- HitDataA, HitDataB  out  DATA_W  youngest pending data for that address; 0 when no hit.
- Count  out  log2(DEPTH)+1  occupancy.

Behaviour:
- Reset (asynchronous, Reset_n low): FIFO empty, Count=0, RegWr=0, RW=ZR_IDX, BusW=0, Stall=0, HitA=HitB=0.
- Enqueue filter: a request whose destination is ZR_IDX is discarded and consumes no slot.
- Enqueue acceptance: requests are sampled on posedge only when Stall=0.
- Simultaneous valid requests:
  - The Mem entry is enqueued first (older), then the ALU entry.
  - Both requests may target the same register; both are kept, and the ALU value wins in program order.
- Stall rule: Stall = (DEPTH - Count) < 2. Registered and combinational derivations are both acceptable, provided Stall is a function of Count only.
  - Stall is therefore high at Count = DEPTH-1 and at Count = DEPTH.
  - Two free slots always exist when Stall=0, so enqueue can never overflow.
- Drain: each posedge with Count>0 pops the head into registered outputs (RegWr=1, RW, BusW) for exactly one cycle. With Count=0, RegWr=0 and RW/BusW hold their last values.
- Latency and ordering:
  - A request accepted at edge N is enqueued at edge N.
  - If the FIFO was empty, it is popped at edge N+1 and presented on RegWr during cycle N+1.
  - The register file commits on the following negedge.
  - Writes retire strictly in enqueue order.
- Push and pop in the same edge:
  - Count updates by (pushes - pop).
  - A push into an empty FIFO is not popped in the same edge; there is no fall-through.
- Pointers: head and tail wrap modulo DEPTH. Count distinguishes full from empty.
- Bypass (combinational):
  - Search the FIFO entries plus the output register while RegWr=1.
  - Return the youngest match; the output register is the oldest candidate.
  - A lookup of ZR_IDX never hits.
- Reset asserted mid-operation: all queued writes are dropped, and RegWr falls immediately (asynchronously).

Decomposition:
- Shared package holds:
  - DATA_W and ADDR_W constants.
  - ZR_IDX constant.
  - A wb_entry struct {rd, data}.
- One sub-module, wb_fifo: storage, pointers and Count, with push0/push1/pop and an entry-array view for the bypass search.
- The top level holds the enqueue filter, the Stall rule, the output register and the two bypass comparators.

Test Plan:
- Reset with Reset_n=0 mid-stream, 3 entries queued -> RegWr=0 immediately; Count=0; no further writes issued after release.
- Single ALU write to X5 = 0x1234 into an empty queue -> RegWr=1, RW=5, BusW=0x1234 one cycle later, for exactly one cycle; Count returns to 0.
- Same-cycle Mem X3=0xAA and ALU X3=0xBB -> writes retire in order 0xAA then 0xBB; LookA=3 returns 0xBB while both are pending and 0xAA never wins.
- Fill with DEPTH=4 while backpressured -> Stall=1 at Count=3 and Count=4; requests presented during Stall are not enqueued; after drain, the retired sequence matches the accepted requests exactly.
- Write to X31 with data 0xFFFF -> no entry created, RegWr stays 0, HitA=0 for LookA=31.
- Continuous one-request-per-cycle stream of 20 writes -> pointer wrap-around exercised; Count stays at or below 1; all 20 writes retire in order with no loss.
